// File: rtl/debounce_bank.sv
// debounce_bank: WIDTH independent switch/key debouncers. Each channel has a 2-flop synchroniser,
// a tick-gated calming window and a registered clean level with single-cycle rise/fall pulses.
module debounce_bank #(
    parameter int   WIDTH       = 18,
    parameter int   CNT_W       = 8,
    parameter int   WINDOW      = 100,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] db,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    typedef enum logic [1:0] {
        ST_ZERO    = 2'd0,
        MAYBE_ONE  = 2'd1,
        ST_ONE     = 2'd2,
        MAYBE_ZERO = 2'd3
    } state_t;

    localparam state_t           RST_STATE = RESET_LEVEL ? ST_ONE : ST_ZERO;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] RST_VEC   = {WIDTH{RESET_LEVEL}};

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    state_t           state_q [WIDTH];
    state_t           state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];
    logic [WIDTH-1:0] db_q;
    logic [WIDTH-1:0] db_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;
    logic             changed_q;
    logic             changed_d;

    // Two-stage synchroniser; reset to the assumed idle level so no edge is seen after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= RST_VEC;
            sync_q <= RST_VEC;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    // Per-channel qualification FSM, window counter and pulse generation.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
        end
        db_d   = db_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (state_q[i])
                ST_ZERO: begin
                    if (sync_q[i]) begin
                        state_d[i] = MAYBE_ONE;
                        cnt_d[i]   = '0;
                    end else begin
                        state_d[i] = ST_ZERO;
                    end
                end
                MAYBE_ONE: begin
                    if (!sync_q[i]) begin
                        state_d[i] = ST_ZERO;
                        cnt_d[i]   = '0;
                    end else if (tick) begin
                        if (cnt_q[i] == CNT_LAST) begin
                            state_d[i] = ST_ONE;
                            cnt_d[i]   = '0;
                            db_d[i]    = 1'b1;
                            rise_d[i]  = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_ONE;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i];
                    end
                end
                ST_ONE: begin
                    if (!sync_q[i]) begin
                        state_d[i] = MAYBE_ZERO;
                        cnt_d[i]   = '0;
                    end else begin
                        state_d[i] = ST_ONE;
                    end
                end
                MAYBE_ZERO: begin
                    if (sync_q[i]) begin
                        state_d[i] = ST_ONE;
                        cnt_d[i]   = '0;
                    end else if (tick) begin
                        if (cnt_q[i] == CNT_LAST) begin
                            state_d[i] = ST_ZERO;
                            cnt_d[i]   = '0;
                            db_d[i]    = 1'b0;
                            fall_d[i]  = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_ONE;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i];
                    end
                end
                default: begin
                    state_d[i] = RST_STATE;
                    cnt_d[i]   = '0;
                    db_d[i]    = RESET_LEVEL;
                end
            endcase
        end
        changed_d = |(rise_d | fall_d);
    end

    // State, counters and all outputs registered together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= RST_STATE;
                cnt_q[i]   <= '0;
            end
            db_q      <= RST_VEC;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            db_q      <= db_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign db      = db_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: three instances (window 4 / reset level 0, window 4 /
// reset level 1, window 1 / reset level 0) against a timestamp-based reference model.
module tb_debounce_bank;

    localparam int W    = 4;
    localparam int NDUT = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         tick = 1'b1;
    logic [W-1:0] din = 4'hF;

    logic [W-1:0] db0, rise0, fall0;
    logic [W-1:0] db1, rise1, fall1;
    logic [W-1:0] db2, rise2, fall2;
    logic         chg0, chg1, chg2;

    int checks = 0;
    int errors = 0;

    // Reference model: accepted level plus a "window open" flag and the tick timestamp at which
    // the window opened; a change is accepted once WINDOW ticks have elapsed since that timestamp.
    logic [W-1:0] m_db   [NDUT];
    logic [W-1:0] m_s1   [NDUT];
    logic [W-1:0] m_sync [NDUT];
    logic [W-1:0] m_rise [NDUT];
    logic [W-1:0] m_fall [NDUT];
    bit           in_win [NDUT][W];
    int           ts     [NDUT][W];
    int           tcnt = 0;
    int           m_pulses [NDUT];
    int           d_pulses [NDUT];

    debounce_bank #(.WIDTH(W), .CNT_W(3), .WINDOW(4), .RESET_LEVEL(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .tick(tick), .din(din),
        .db(db0), .rise(rise0), .fall(fall0), .changed(chg0));
    debounce_bank #(.WIDTH(W), .CNT_W(3), .WINDOW(4), .RESET_LEVEL(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .tick(tick), .din(din),
        .db(db1), .rise(rise1), .fall(fall1), .changed(chg1));
    debounce_bank #(.WIDTH(W), .CNT_W(8), .WINDOW(1), .RESET_LEVEL(1'b0)) u_dut2 (
        .clk(clk), .rst(rst), .tick(tick), .din(din),
        .db(db2), .rise(rise2), .fall(fall2), .changed(chg2));

    always #5 clk = ~clk;

    function automatic int win_of(input int r);
        return (r == 2) ? 1 : 4;
    endfunction

    function automatic logic rl_of(input int r);
        return (r == 1) ? 1'b1 : 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NDUT; r++) begin
            m_db[r]   = {W{rl_of(r)}};
            m_s1[r]   = {W{rl_of(r)}};
            m_sync[r] = {W{rl_of(r)}};
            m_rise[r] = '0;
            m_fall[r] = '0;
            for (int c = 0; c < W; c++) begin
                in_win[r][c] = 1'b0;
                ts[r][c]     = 0;
            end
        end
    endtask

    task automatic model_edge(input logic [W-1:0] d, input logic t);
        for (int r = 0; r < NDUT; r++) begin
            m_rise[r] = '0;
            m_fall[r] = '0;
            for (int c = 0; c < W; c++) begin
                if (!in_win[r][c]) begin
                    if (m_sync[r][c] != m_db[r][c]) begin
                        in_win[r][c] = 1'b1;
                        ts[r][c]     = tcnt + (t ? 1 : 0);
                    end
                end else if (m_sync[r][c] == m_db[r][c]) begin
                    in_win[r][c] = 1'b0;
                end else if (t && (tcnt + 1 - ts[r][c] == win_of(r))) begin
                    m_db[r][c]   = ~m_db[r][c];
                    in_win[r][c] = 1'b0;
                    m_pulses[r]++;
                    if (m_db[r][c]) m_rise[r][c] = 1'b1;
                    else            m_fall[r][c] = 1'b1;
                end
            end
            m_sync[r] = m_s1[r];
            m_s1[r]   = d;
        end
        if (t) tcnt++;
    endtask

    task automatic compare_all(input string tag);
        logic [W-1:0] o_db, o_rise, o_fall;
        logic         o_chg;
        for (int r = 0; r < NDUT; r++) begin
            case (r)
                0:       begin o_db = db0; o_rise = rise0; o_fall = fall0; o_chg = chg0; end
                1:       begin o_db = db1; o_rise = rise1; o_fall = fall1; o_chg = chg1; end
                default: begin o_db = db2; o_rise = rise2; o_fall = fall2; o_chg = chg2; end
            endcase
            d_pulses[r] += $countones(o_rise) + $countones(o_fall);
            check($sformatf("%s_db%0d", tag, r),   32'(o_db),   32'(m_db[r]));
            check($sformatf("%s_rise%0d", tag, r), 32'(o_rise), 32'(m_rise[r]));
            check($sformatf("%s_fall%0d", tag, r), 32'(o_fall), 32'(m_fall[r]));
            check($sformatf("%s_chg%0d", tag, r),  32'(o_chg),  32'(|(m_rise[r] | m_fall[r])));
        end
    endtask

    // Called at a falling edge: drive inputs, let one rising edge pass, compare at the next fall.
    task automatic step(input string tag, input logic [W-1:0] d, input logic t);
        din  = d;
        tick = t;
        @(posedge clk);
        model_edge(d, t);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic do_reset(input logic [W-1:0] d, input int cyc);
        rst  = 1'b0;
        din  = d;
        tick = 1'b1;
        #1;
        model_reset();
        compare_all("rst_async");
        for (int k = 0; k < cyc; k++) begin
            @(posedge clk);
            @(negedge clk);
            compare_all("rst_hold");
        end
        rst = 1'b1;
    endtask

    initial begin
        int cnt;
        logic [W-1:0] rd;
        logic         rt;
        for (int r = 0; r < NDUT; r++) begin
            m_pulses[r] = 0;
            d_pulses[r] = 0;
        end
        model_reset();
        @(negedge clk);
        do_reset(4'hF, 4);
        for (int k = 0; k < 20; k++) begin
            step("idle", 4'h0, 1'b1);
            check("idle_db0", 32'(db0), 32'h0);
        end

        // Clean edge on channel 0: window 4 accepts at edge 6, window 1 at edge 3.
        for (int k = 0; k < 8; k++) begin
            step("clean_up", 4'h1, 1'b1);
            check("lat_rise_w4", 32'(rise0[0]), 32'(k == 6));
            check("lat_rise_w1", 32'(rise2[0]), 32'(k == 3));
        end
        for (int k = 0; k < 8; k++) begin
            step("clean_dn", 4'h0, 1'b1);
            check("lat_fall_w4", 32'(fall0[0]), 32'(k == 6));
        end

        // Bounce on channel 1: high 3, low 1, then held high.
        cnt = 0;
        for (int k = 0; k < 14; k++) begin
            step("bounce", (k == 3) ? 4'h0 : 4'h2, 1'b1);
            check("bounce_rise", 32'(rise0[1]), 32'(k == 10));
            cnt += $countones(rise0);
        end
        check("bounce_count", 32'(cnt), 32'd1);

        // Simultaneous rise on all channels, then channel 2 falls alone.
        for (int k = 0; k < 8; k++) step("settle", 4'h0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step("simul_up", 4'hF, 1'b1);
            check("simul_rise", 32'(rise0), (k == 6) ? 32'hF : 32'h0);
            check("simul_chg", 32'(chg0), 32'(k == 6));
        end
        for (int k = 0; k < 8; k++) begin
            step("simul_dn", 4'hB, 1'b1);
            check("single_fall", 32'(fall0), (k == 6) ? 32'h4 : 32'h0);
        end

        // Tick every 4th cycle stretches the window; a short glitch is still rejected.
        for (int k = 0; k < 8; k++) step("settle", 4'h0, 1'b1);
        for (int k = 0; k < 30; k++) begin
            step("tick_gate", 4'h1, 1'(k % 4 == 3));
            check("tick_gate_early", 32'(db0[0] && (k < 12)), 32'h0);
        end
        for (int k = 0; k < 6; k++) step("tick_glitch", 4'h0, 1'(k % 4 == 3));
        for (int k = 0; k < 30; k++) step("tick_gate2", 4'h1, 1'(k % 4 == 3));

        // Reset in the middle of a qualification window.
        for (int k = 0; k < 8; k++) step("settle", 4'h0, 1'b1);
        for (int k = 0; k < 4; k++) step("mid_win", 4'h1, 1'b1);
        do_reset(4'h0, 2);
        for (int k = 0; k < 10; k++) begin
            step("post_rst", 4'h0, 1'b1);
            check("post_rst_no_rise", 32'(rise0), 32'h0);
            check("rl1_fall", 32'(fall1), (k == 6) ? 32'hF : 32'h0);
        end

        // Randomised phases: continuous tick, sparse tick, random tick.
        for (int ph = 0; ph < 3; ph++) begin
            rd = 4'h0;
            for (int k = 0; k < 1200; k++) begin
                for (int c = 0; c < W; c++) begin
                    if ($urandom_range(0, (ph == 0) ? 9 : 30) == 0) rd[c] = ~rd[c];
                end
                case (ph)
                    0:       rt = 1'b1;
                    1:       rt = 1'(k % 4 == 0);
                    default: rt = 1'($urandom_range(0, 1));
                endcase
                step($sformatf("rand%0d", ph), rd, rt);
            end
        end

        for (int r = 0; r < NDUT; r++) begin
            check($sformatf("pulse_total%0d", r), 32'(d_pulses[r]), 32'(m_pulses[r]));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel debouncer for slide switches and push-buttons. Each of WIDTH independent channels synchronises its raw input, qualifies a level change over a configurable calming window counted in enable ticks, and drives a clean level plus single-cycle rise/fall pulses. It sits between the board switch/key pins and all control logic, and supersedes the fixed 18-switch debouncer.

## Interface
- WIDTH, 18, number of independent channels
- CNT_W, 8, calming-window counter width
- WINDOW, 100, consecutive stable ticks required to accept a change; legal range 1 .. 2**CNT_W-1
- RESET_LEVEL, 0, level assumed for every channel at reset (1'b0 for switches, 1'b1 for active-low keys)
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset
- tick  input  1  count enable; the window advances only on cycles with tick=1 (tie to 1'b1 to count clocks)
- din  input  WIDTH  raw asynchronous switch/key levels
- db  output  WIDTH  debounced level, registered
- rise  output  WIDTH  one-cycle pulse on the cycle db[i] first reads 1
- fall  output  WIDTH  one-cycle pulse on the cycle db[i] first reads 0
- changed  output  1  OR-reduction of rise|fall, same cycle as the pulses

## Operation
- Per channel: 2-flop synchroniser on din[i] → sync[i]; all decisions use sync[i] only.
- Per-channel FSM, 2-bit state: ST_ZERO, MAYBE_ONE, ST_ONE, MAYBE_ZERO. No other states reachable; unused encodings go to the RESET_LEVEL stable state.
- ST_ZERO: sync=1 → MAYBE_ONE, count←0; else stay.
- MAYBE_ONE: sync=0 → ST_ZERO, count←0, no pulse (glitch rejected). sync=1 and tick=1 and count==WINDOW-1 → ST_ONE, db←1, rise←1. sync=1 and tick=1 otherwise → count+1. tick=0 → hold count.
- ST_ONE / MAYBE_ZERO mirror the above with levels inverted; acceptance sets db←0, fall←1.
- db[i]=1 exactly in ST_ONE and MAYBE_ZERO; db never changes while in a MAYBE state.
- count never exceeds WINDOW-1; no wrap. Counters are per channel, unsigned CNT_W bits.
- rise/fall are cleared every cycle they are not being set; rise and fall of one channel are never both 1.
- Channels are fully independent; simultaneous acceptances on several channels each pulse in the same cycle; changed=1 once.

## Timing
- Reset (async, rst=0): sync flops, state, db all = RESET_LEVEL; count=0; rise=fall=0; changed=0. Reset asserted mid-window aborts the window with no pulse.
- Latency, tick=1 constant: din sampled at edge 0 and held → db and the pulse visible after edge WINDOW+2 (2 sync + 1 entry to MAYBE + WINDOW counting edges).
- With WINDOW=1: MAYBE lasts exactly one qualifying tick edge.
- Ticks while in a stable state are ignored. tick=0 for N cycles stretches latency by N cycles.
- Any bounce (sync returning to the old level) of one or more cycles during MAYBE restarts qualification from the next change; total pulse count equals number of accepted level changes.
- rise/fall/changed are registered, width exactly one clk cycle regardless of tick.

## Test plan
- Reset: WIDTH=4, RESET_LEVEL=0, din=4'hF during rst=0 → db=0, rise=fall=0, changed=0; release with din=0 → outputs unchanged for 20 cycles.
- Clean edge: WINDOW=4, tick=1, din[0] 0→1 held → db[0]=1 and rise[0]=1 after edge 6, rise[0]=0 next cycle; later 1→0 → fall[0] pulse after edge 6 of that change.
- Bounce: din[1] high 3 cycles, low 1, high held (WINDOW=4) → no pulse during bounce; single rise[1] 6 edges after final high sample; exactly one rise counted.
- Tick gating: tick high every 4th cycle, WINDOW=4 → db change delayed by ~4x window; count holds on tick=0; glitch shorter than the window still rejected.
- Simultaneous: din[3:0] 0→F same cycle → rise=4'hF for one cycle, changed=1 for one cycle; then din[2] falls alone → fall=4'h4 only.
- Reset mid-window and RESET_LEVEL=1: rst pulsed while channel in MAYBE_ONE → no rise, count=0; with RESET_LEVEL=1 db=all ones after reset and din low accepted produces fall pulses.
